// File: rtl/sa_ram_rws_param.sv
// rtl/sa_ram_rws_param.sv - parametrised 1R1W synchronous RAM with byte masks, RDW policy and init sweep
module sa_ram_rws_param #(
  parameter int DW            = 64,
  parameter int AW            = 7,
  parameter int BYPASS        = 1,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  output logic [DW-1:0]     dout,
  output logic              dout_vld,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [DW/8-1:0]   wmask,
  input  logic [DW-1:0]     di,
  output logic              init_busy,
  input  logic [31:0]       pwrbus_ram_pd
);

  localparam int MW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            init_busy_q;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_word_d;
  logic [DW-1:0]   rd_data_q;
  logic            rd_vld_q;
  logic            rd_en;
  logic            wr_en;
  logic            unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;
  assign rd_en         = (state_q == ST_RUN) && re;
  assign wr_en         = (state_q == ST_RUN) && we;
  assign init_busy     = init_busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_busy_q <= (INIT_ON_RESET != 0);
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_q     <= ST_RUN;
        init_busy_q <= 1'b0;
      end
    end
  end

  // The array itself is never reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < MW; i++) begin
        if (wmask[i]) mem[wa][8*i +: 8] <= di[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word_d = mem[ra];
    if ((BYPASS != 0) && wr_en && (wa == ra)) begin
      for (int i = 0; i < MW; i++) begin
        if (wmask[i]) rd_word_d[8*i +: 8] = di[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] out_data_q;
      logic          out_vld_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else begin
          out_vld_q <= rd_vld_q;
          if (rd_vld_q) out_data_q <= rd_data_q;
        end
      end

      assign dout     = out_data_q;
      assign dout_vld = out_vld_q;
    end else begin : g_no_out_reg
      assign dout     = rd_data_q;
      assign dout_vld = rd_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sa_ram_rws_param.sv
// tb/tb_sa_ram_rws_param.sv - directed bench: write-first/no-outreg and read-first/outreg instances
module tb_sa_ram_rws_param;

  logic        clk;
  logic        rstn;
  logic [3:0]  ra;
  logic        re;
  logic [3:0]  wa;
  logic        we;
  logic [7:0]  wmask;
  logic [63:0] di;
  logic [31:0] pwrbus_ram_pd;

  logic [63:0] wf_dout, rf_dout;
  logic        wf_vld, rf_vld;
  logic        wf_busy, rf_busy;

  int vectors;
  int miscompares;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] AAS  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] FIVS = 64'h5555_5555_5555_5555;
  localparam logic [63:0] M1   = 64'h0101_0101_0101_0101;
  localparam logic [63:0] M2   = 64'h0202_0202_0202_0202;
  localparam logic [63:0] M3   = 64'h0303_0303_0303_0303;

  sa_ram_rws_param #(.DW(64), .AW(4), .BYPASS(1), .OUT_REG(0), .INIT_ON_RESET(1)) u_wf (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(wf_dout), .dout_vld(wf_vld),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .init_busy(wf_busy), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  sa_ram_rws_param #(.DW(64), .AW(4), .BYPASS(0), .OUT_REG(1), .INIT_ON_RESET(1)) u_rf (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(rf_dout), .dout_vld(rf_vld),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .init_busy(rf_busy), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hammers re/we during the sweep and measures how many edges init_busy stays high.
  task automatic wait_init(input string tag);
    int kwf, krf;
    logic vld_seen;
    kwf = 0; krf = 0; vld_seen = 1'b0;
    re = 1'b1; ra = 4'd0; we = 1'b1; wa = 4'd0; wmask = 8'hFF; di = ONES;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (wf_vld || rf_vld) vld_seen = 1'b1;
      if (!wf_busy && kwf == 0) kwf = k;
      if (!rf_busy && krf == 0) krf = k;
      if (kwf != 0 && krf != 0) break;
    end
    re = 1'b0; we = 1'b0;
    chk({tag, "_wf_busy_cycles"}, 64'(kwf), 64'd16);
    chk({tag, "_rf_busy_cycles"}, 64'(krf), 64'd16);
    chk({tag, "_no_vld_in_init"}, 64'(vld_seen), 64'd0);
  endtask

  task automatic read_all_zero(input string tag);
    int cwf, crf, bad;
    cwf = 0; crf = 0; bad = 0;
    for (int a = 0; a < 18; a++) begin
      re = (a < 16);
      ra = 4'(a);
      tick();
      if (wf_vld) begin cwf++; if (wf_dout !== 64'd0) bad++; end
      if (rf_vld) begin crf++; if (rf_dout !== 64'd0) bad++; end
    end
    re = 1'b0;
    chk({tag, "_wf_vld_count"}, 64'(cwf), 64'd16);
    chk({tag, "_rf_vld_count"}, 64'(crf), 64'd16);
    chk({tag, "_nonzero_words"}, 64'(bad), 64'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
    we = 1'b1; wa = a; di = d; wmask = m;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a,
                          input logic [63:0] exp_wf, input logic [63:0] exp_rf);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0;
    chk({tag, "_wf_vld"}, 64'(wf_vld), 64'd1);
    chk({tag, "_wf_dout"}, wf_dout, exp_wf);
    chk({tag, "_rf_vld_early"}, 64'(rf_vld), 64'd0);
    tick();
    chk({tag, "_rf_vld"}, 64'(rf_vld), 64'd1);
    chk({tag, "_rf_dout"}, rf_dout, exp_rf);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rstn = 1'b1; re = 1'b0; ra = '0; we = 1'b0; wa = '0; wmask = '0; di = '0;
    pwrbus_ram_pd = 32'h0;

    #1 rstn = 1'b0;
    #1;
    chk("rst_wf_dout", wf_dout, 64'd0);
    chk("rst_wf_vld", 64'(wf_vld), 64'd0);
    chk("rst_wf_busy", 64'(wf_busy), 64'd1);
    chk("rst_rf_dout", rf_dout, 64'd0);
    chk("rst_rf_busy", 64'(rf_busy), 64'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    wait_init("init1");
    read_all_zero("zero1");

    wr(4'd3, ONES, 8'hFF);
    wr(4'd3, 64'h1122_3344_5566_7788, 8'h0F);
    rd_check("mask", 4'd3, 64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788);
    wr(4'd3, 64'd0, 8'h00);
    rd_check("mask0", 4'd3, 64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788);

    wr(4'd5, AAS, 8'hFF);
    re = 1'b1; ra = 4'd5; we = 1'b1; wa = 4'd5; di = FIVS; wmask = 8'hF0;
    tick();
    re = 1'b0; we = 1'b0;
    chk("coll_wf_dout", wf_dout, 64'h5555_5555_AAAA_AAAA);
    tick();
    chk("coll_rf_dout", rf_dout, AAS);
    rd_check("coll_after", 4'd5, 64'h5555_5555_AAAA_AAAA, 64'h5555_5555_AAAA_AAAA);

    wr(4'd1, M1, 8'hFF);
    wr(4'd2, M2, 8'hFF);
    wr(4'd3, M3, 8'hFF);
    re = 1'b1; ra = 4'd1;
    tick();
    chk("lat_c0_wf_vld", 64'(wf_vld), 64'd1);
    chk("lat_c0_wf_dout", wf_dout, M1);
    chk("lat_c0_rf_vld", 64'(rf_vld), 64'd0);
    ra = 4'd2;
    tick();
    chk("lat_c1_wf_dout", wf_dout, M2);
    chk("lat_c1_rf_vld", 64'(rf_vld), 64'd1);
    chk("lat_c1_rf_dout", rf_dout, M1);
    ra = 4'd3;
    tick();
    chk("lat_c2_wf_vld", 64'(wf_vld), 64'd1);
    chk("lat_c2_wf_dout", wf_dout, M3);
    chk("lat_c2_rf_dout", rf_dout, M2);
    re = 1'b0; we = 1'b1; wa = 4'd3; di = 64'hDEAD_BEEF_DEAD_BEEF; wmask = 8'hFF;
    tick();
    we = 1'b0;
    chk("hold_c3_wf_vld", 64'(wf_vld), 64'd0);
    chk("hold_c3_wf_dout", wf_dout, M3);
    chk("hold_c3_rf_vld", 64'(rf_vld), 64'd1);
    chk("hold_c3_rf_dout", rf_dout, M3);
    tick();
    chk("hold_c4_rf_vld", 64'(rf_vld), 64'd0);
    chk("hold_c4_wf_dout", wf_dout, M3);
    chk("hold_c4_rf_dout", rf_dout, M3);
    tick();
    chk("hold_c5_wf_dout", wf_dout, M3);
    chk("hold_c5_rf_dout", rf_dout, M3);

    #2 rstn = 1'b0;
    #1;
    chk("arst_wf_dout", wf_dout, 64'd0);
    chk("arst_rf_dout", rf_dout, 64'd0);
    chk("arst_wf_busy", 64'(wf_busy), 64'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (7) tick();
    chk("midinit_busy", 64'(wf_busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_wf_vld", 64'(wf_vld), 64'd0);
    chk("midrst_rf_busy", 64'(rf_busy), 64'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_init("init2");
    read_all_zero("zero2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sa_ram_rws_param.md
# sa_ram_rws_param

Parametrised 1-read/1-write synchronous RAM model for the systolic-array buffer hierarchy, superseding the fixed-size 1R1W RAM models. It adds byte-lane write masking, a selectable read-during-write policy, an optional output pipeline register, a read-valid strobe, and a post-reset zero-initialisation sweep, so consumers never read X contents. It sits wherever a scratchpad or skew buffer needs one read port and one write port on a single clock.

## Interface
- DW, 64, data width in bits; multiple of 8.
- AW, 7, address width; DEPTH = 2**AW entries.
- MW, DW/8, byte-mask width; derived, not overridden.
- BYPASS, 1, 1 = write-first (same-address write forwarded to the read); 0 = read-first (old data returned).
- OUT_REG, 0, 1 = extra output register stage, adding one cycle of read latency.
- INIT_ON_RESET, 1, 1 = zero every entry after reset; 0 = no sweep, contents undefined.

- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ra  in  AW  read address.
- re  in  1  read enable.
- dout  out  DW  read data; holds its last value when no new read completes.
- dout_vld  out  1  one-cycle strobe marking the cycle in which dout carries a new read result.
- wa  in  AW  write address.
- we  in  1  write enable.
- wmask  in  MW  byte-lane write enable; bit i covers di[8i+7:8i].
- di  in  DW  write data.
- init_busy  out  1  high while the init sweep runs.
- pwrbus_ram_pd  in  32  power-domain control; no functional effect in this model.

## Operation
- State machine with two states, INIT and RUN.
  - Reset enters INIT when INIT_ON_RESET=1 and RUN when INIT_ON_RESET=0.
  - In INIT, an AW-bit counter starts at 0 and writes all-zeros to M[cnt] each cycle with the full mask.
  - When cnt = DEPTH-1 is written, the block moves to RUN. The sweep takes DEPTH cycles.
- During INIT:
  - re and we are ignored; no user write lands.
  - No read is issued, so dout_vld stays 0.
- Write in RUN: when we=1, each lane i with wmask[i]=1 updates M[wa][8i+7:8i] from di. Lanes with wmask[i]=0 keep their contents. If wmask=0, nothing is written.
- Read in RUN: when re=1, the stage-1 data register captures M[ra] at the clock edge. Data is registered, not the address, so later writes never alter dout that has already been returned.
- Collision, when re=1, we=1 and ra==wa in the same cycle:
  - BYPASS=1: the returned word is merged. Masked lanes come from di; the other lanes are the old contents.
  - BYPASS=0: the returned word is the old contents.
  - In both modes the memory is updated.
- re=0: the data registers hold; dout is unchanged.
- Reset mid-operation:
  - All registers clear: dout=0, dout_vld=0, counter=0.
  - With INIT_ON_RESET=1 the block re-enters INIT and re-sweeps from address 0. Memory array contents are not reset directly.
- Reset values:
  - dout=0 and dout_vld=0.
  - init_busy=1 when INIT_ON_RESET=1, otherwise 0.
  - Internal state: stage-1 data register=0, stage-1 valid register=0, OUT_REG stage registers=0.

## Timing
- Read latency with OUT_REG=0: re sampled at edge N → dout and dout_vld valid after edge N (cycle N+1).
- Read latency with OUT_REG=1: one more cycle, so valid in cycle N+2.
- dout_vld pipeline: it is re delayed through the same stages as the data. Back-to-back reads give back-to-back strobes at full throughput.
- Write visibility: a write at edge N is visible to a read sampled at edge N+1. Same-edge visibility follows the BYPASS rule.
- Init handover: init_busy is high for exactly DEPTH cycles after rstn deasserts. It falls with the edge that writes address DEPTH-1, so the first accepted user operation is sampled on the next edge.
- Async reset asserts immediately, without waiting for clk. Deassertion is expected to be synchronised upstream.

## Test plan
- Init sweep (AW=4, INIT_ON_RESET=1): release reset.
  - init_busy stays high 16 cycles, then drops.
  - Reads of all 16 addresses return 0 with one dout_vld per read.
  - re/we asserted during init have no effect.
- Masked write (DW=64): write 0xFFFF_FFFF_FFFF_FFFF to addr 3 with mask 0xFF, then 0x1122_3344_5566_7788 with mask 0x0F.
  - A read of addr 3 returns 0xFFFF_FFFF_5566_7788.
- Collision: M[5]=0xAAAA…AA; same cycle we=1, re=1, wa=ra=5, di=0x5555…55, mask 0xF0.
  - BYPASS=1 returns 0x5555_5555_AAAA_AAAA.
  - BYPASS=0 returns 0xAAAA…AA.
  - A subsequent read returns 0x5555_5555_AAAA_AAAA in both modes.
- Latency and hold (OUT_REG=0, then 1): reads of addrs 1,2,3 back-to-back, then re=0 for 3 cycles.
  - dout_vld pulses 3 consecutive cycles starting 1 (resp. 2) cycles after the first re.
  - dout then holds M[3] while a write to addr 3 occurs.
- Reset mid-init: assert rstn low at sweep cycle 7 of 16, then release.
  - dout=0 and dout_vld=0 immediately.
  - init_busy stays high a full 16 cycles after release.
  - All entries read back 0.
